// File: rtl/wb_bram_pkg.sv
// Shared types, widths and the byte-lane merge helper for the Wishbone BRAM slave.
package wb_bram_pkg;

   localparam int unsigned DATA_WIDTH     = 32;
   localparam int unsigned ADDR_WIDTH     = 14;
   localparam int unsigned SEL_WIDTH      = DATA_WIDTH / 8;
   localparam int unsigned OFS_WIDTH      = $clog2(SEL_WIDTH);
   localparam int unsigned BUS_ADDR_WIDTH = ADDR_WIDTH + OFS_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RMW,
      ACK
   } state_t;

   // Request captured when a strobe is accepted in IDLE
   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [SEL_WIDTH-1:0]  sel;
   } req_t;

   function automatic logic [DATA_WIDTH-1:0] byte_merge(
      input logic [DATA_WIDTH-1:0] old_word,
      input logic [DATA_WIDTH-1:0] new_word,
      input logic [SEL_WIDTH-1:0]  sel
   );
      logic [DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < SEL_WIDTH; i++) begin
         if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_bram_if.sv
// Wishbone classic-cycle bus between a master and the BRAM slave.
interface wb_bram_if;
   import wb_bram_pkg::*;

   logic                      wb_cyc_i;
   logic                      wb_stb_i;
   logic                      wb_we_i;
   logic [BUS_ADDR_WIDTH-1:0] wb_adr_i;
   logic [DATA_WIDTH-1:0]     wb_dat_i;
   logic [SEL_WIDTH-1:0]      wb_sel_i;
   logic [DATA_WIDTH-1:0]     wb_dat_o;
   logic                      wb_ack_o;

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/wb_bram_slave.sv
// Wishbone slave fronting a single-port BRAM: hides read latency and
// turns byte-lane writes into read-modify-write of the full word.
module wb_bram_slave
   import wb_bram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   wb_bram_if.slave              wb,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic                  bram_w_en,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   input  logic [DATA_WIDTH-1:0] bram_rdata
);

   state_t                state_q, state_d;
   req_t                  req_q;
   logic [DATA_WIDTH-1:0] dat_q;

   logic                  req_c;
   logic                  full_c;
   logic                  zero_c;
   logic [ADDR_WIDTH-1:0] adr_word_c;
   logic                  unused_adr_ofs;

   assign adr_word_c     = wb.wb_adr_i[BUS_ADDR_WIDTH-1:OFS_WIDTH];
   assign unused_adr_ofs = ^wb.wb_adr_i[OFS_WIDTH-1:0];
   assign req_c          = wb.wb_cyc_i & wb.wb_stb_i;
   assign full_c         = &wb.wb_sel_i;
   assign zero_c         = ~|wb.wb_sel_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Capture address, data and lanes on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_q <= '0;
      end else if (state_q == IDLE && req_c) begin
         req_q <= '{addr: adr_word_c, wdata: wb.wb_dat_i, sel: wb.wb_sel_i};
      end
   end

   // Read data is held until the next completed read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_q <= '0;
      end else if (state_q == RD_WAIT && wb.wb_cyc_i) begin
         dat_q <= bram_rdata;
      end
   end

   always_comb begin
      state_d    = state_q;
      bram_addr  = adr_word_c;
      bram_w_en  = 1'b0;
      bram_wdata = '0;

      case (state_q)
         IDLE: begin
            if (req_c) begin
               if (!wb.wb_we_i) begin
                  state_d = RD_WAIT;
               end else if (full_c || zero_c) begin
                  state_d = ACK;
                  // Full-word writes go straight through; gated so reset never writes
                  if (full_c && !rst) begin
                     bram_w_en  = 1'b1;
                     bram_wdata = wb.wb_dat_i;
                  end
               end else begin
                  state_d = RMW;
               end
            end
         end
         RD_WAIT: begin
            bram_addr = req_q.addr;
            state_d   = wb.wb_cyc_i ? ACK : IDLE;
         end
         RMW: begin
            // bram_rdata holds the old word this cycle
            bram_addr  = req_q.addr;
            bram_wdata = byte_merge(bram_rdata, req_q.wdata, req_q.sel);
            bram_w_en  = wb.wb_cyc_i;
            state_d    = wb.wb_cyc_i ? ACK : IDLE;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign wb.wb_ack_o = (state_q == ACK) & wb.wb_cyc_i;
   assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_bram_slave.sv
// Scoreboard bench for wb_bram_slave with a behavioural one-cycle-latency BRAM.
module tb_wb_bram_slave;
   import wb_bram_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_bram_if wb();

   logic [ADDR_WIDTH-1:0] bram_addr;
   logic                  bram_w_en;
   logic [DATA_WIDTH-1:0] bram_wdata;
   logic [DATA_WIDTH-1:0] bram_rdata;

   wb_bram_slave dut (
      .clk        (clk),
      .rst        (rst),
      .wb         (wb),
      .bram_addr  (bram_addr),
      .bram_w_en  (bram_w_en),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata)
   );

   // Read-first single-port BRAM
   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
   always @(posedge clk) begin
      if (bram_w_en) mem[bram_addr] <= bram_wdata;
      bram_rdata <= mem[bram_addr];
   end

   int cnt = 0;
   always @(posedge clk) cnt <= cnt + 1;

   typedef struct {
      logic        is_rd;
      logic [31:0] data;
      int          at;
      int          gap;
   } ack_exp_t;

   typedef struct {
      logic [13:0] addr;
      logic [31:0] data;
      int          at;
   } wr_exp_t;

   ack_exp_t ack_q[$];
   wr_exp_t  wr_q[$];
   ack_exp_t ae;
   wr_exp_t  we_e;
   int checks = 0;
   int errors = 0;
   int last_ack = -100;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cnt);
      end
   endtask

   // Monitor: pop and compare on every ack and every BRAM write
   always @(negedge clk) begin
      if (!rst) begin
         if (wb.wb_ack_o) begin
            if (ack_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cnt);
            end else begin
               ae = ack_q.pop_front();
               check("ack_cycle", 32'(cnt), 32'(ae.at));
               if (ae.is_rd) check("rd_data", wb.wb_dat_o, ae.data);
               if (ae.gap > 0) check("ack_gap", 32'(cnt - last_ack), 32'(ae.gap));
            end
            last_ack = cnt;
         end
         if (bram_w_en) begin
            if (wr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got write addr %h data %h, expected none",
                        bram_addr, bram_wdata);
            end else begin
               we_e = wr_q.pop_front();
               check("wr_addr", 32'(bram_addr), 32'(we_e.addr));
               check("wr_data", bram_wdata, we_e.data);
               check("wr_cycle", 32'(cnt), 32'(we_e.at));
            end
         end
      end
   end

   // One transfer; wr_off < 0 means no BRAM write is expected
   task automatic do_xfer(input logic we, input logic [15:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp, input int lat,
                          input int gap, input int wr_off);
      int  issue;
      bit  ok;
      ack_exp_t a;
      wr_exp_t  w;
      issue   = cnt;
      a.is_rd = !we;
      a.data  = exp;
      a.at    = issue + lat;
      a.gap   = gap;
      ack_q.push_back(a);
      if (wr_off >= 0) begin
         w.addr = adr[15:2];
         w.data = exp;
         w.at   = issue + wr_off;
         wr_q.push_back(w);
      end
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = we;
      wb.wb_adr_i = adr;
      wb.wb_dat_i = dat;
      wb.wb_sel_i = sel;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb.wb_ack_o) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack for adr %h, expected ack within 10 cycles", adr);
      end
      #1;
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected end within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = 1'b1;
      wb.wb_adr_i = 16'h0010;
      wb.wb_dat_i = 32'hDEADBEEF;
      wb.wb_sel_i = 4'hF;
      #12;
      // Reset state, with a full-write request present that must not write
      check("rst_ack", 32'(wb.wb_ack_o), 32'h0);
      check("rst_dat_o", wb.wb_dat_o, 32'h0);
      check("rst_w_en", 32'(bram_w_en), 32'h0);
      check("rst_wdata", bram_wdata, 32'h0);
      check("rst_addr", 32'(bram_addr), 32'h4);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Preload
      do_xfer(1'b1, 16'h0020, 32'h11223344, 4'hF, 32'h11223344, 1, 0, 0);
      do_xfer(1'b1, 16'h0030, 32'h12345678, 4'hF, 32'h12345678, 1, 0, 0);
      do_xfer(1'b1, 16'h0000, 32'h0BADC0DE, 4'hF, 32'h0BADC0DE, 1, 0, 0);

      // Full write and readback
      do_xfer(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1, 0, 0);
      do_xfer(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, 2, 0, -1);

      // Partial write merges lanes 0 and 2
      do_xfer(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 32'h11BB33DD, 2, 0, 1);
      do_xfer(1'b0, 16'h0020, 32'h0, 4'hF, 32'h11BB33DD, 2, 0, -1);

      // Zero-lane write leaves the word untouched
      do_xfer(1'b1, 16'h0031, 32'hFFFFFFFF, 4'h0, 32'h0, 1, 0, -1);
      do_xfer(1'b0, 16'h0030, 32'h0, 4'h0, 32'h12345678, 2, 0, -1);

      // Partial write aborted in RMW
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = 1'b1;
      wb.wb_adr_i = 16'h0020;
      wb.wb_dat_i = 32'h00000000;
      wb.wb_sel_i = 4'b0011;
      @(posedge clk);
      #1;
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      wb.wb_we_i  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_xfer(1'b0, 16'h0020, 32'h0, 4'h0, 32'h11BB33DD, 2, 0, -1);

      // Reset asserted during RD_WAIT
      wb.wb_cyc_i = 1'b1;
      wb.wb_stb_i = 1'b1;
      wb.wb_we_i  = 1'b0;
      wb.wb_adr_i = 16'h0010;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("rd_rst_ack", 32'(wb.wb_ack_o), 32'h0);
      check("rd_rst_dat_o", wb.wb_dat_o, 32'h0);
      check("rd_rst_w_en", 32'(bram_w_en), 32'h0);
      wb.wb_cyc_i = 1'b0;
      wb.wb_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      do_xfer(1'b0, 16'h0010, 32'h0, 4'hF, 32'hDEADBEEF, 2, 0, -1);

      // Back-to-back at the top of the address range
      do_xfer(1'b1, 16'hFFFC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1, 0, 0);
      do_xfer(1'b0, 16'h0000, 32'h0, 4'hF, 32'h0BADC0DE, 2, 3, -1);
      do_xfer(1'b0, 16'hFFFC, 32'h0, 4'hF, 32'hCAFEF00D, 2, 3, -1);

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ack_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: got %0d acks and %0d writes pending, expected 0",
                  ack_q.size(), wr_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_bram_slave.md
# wb_bram_slave

Wishbone B4 classic-cycle slave that fronts the single-port BRAM and is its only driver, converting bus reads, writes and byte-lane writes into BRAM accesses. It absorbs the BRAM's one-cycle read latency and performs read-modify-write for partial byte selects, since the BRAM only has a full-word write enable. The DMA engine and any test master reach memory exclusively through this block.

## Interface
- DATA_WIDTH, 32: data bus and BRAM word width; a multiple of 8.
- ADDR_WIDTH, 14: BRAM word-address width.
- SEL_WIDTH, DATA_WIDTH/8: byte-select width; derived, not overridden.
- OFS_WIDTH, $clog2(SEL_WIDTH): byte-offset bits; derived.

- clk  in  1  single clock for bus and BRAM.
- rst  in  1  reset; asynchronous and active-high.
- wb_cyc_i  in  1  bus cycle active.
- wb_stb_i  in  1  strobe; qualified by wb_cyc_i.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_WIDTH+OFS_WIDTH  byte address; word = wb_adr_i[ADDR_WIDTH+OFS_WIDTH-1:OFS_WIDTH]; low bits ignored.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_sel_i  in  SEL_WIDTH  byte lanes; bit i covers dat[8i+7:8i].
- wb_dat_o  out  DATA_WIDTH  read data; registered; valid while wb_ack_o=1.
- wb_ack_o  out  1  one-cycle acknowledge.
- bram_addr  out  ADDR_WIDTH  BRAM word address.
- bram_w_en  out  1  BRAM write enable.
- bram_wdata  out  DATA_WIDTH  BRAM write data.
- bram_rdata  in  DATA_WIDTH  BRAM read data; valid one cycle after the address is presented.

## Operation
- FSM states: IDLE, RD_WAIT, RMW, ACK.
- IDLE: bram_addr follows the wb_adr_i word bits combinationally, so every cycle issues a harmless BRAM read. A request is wb_cyc_i & wb_stb_i. On a request, capture the word address, wb_dat_i and wb_sel_i.
- Full write (we=1, sel all ones): in IDLE, drive bram_w_en=1 and bram_wdata=wb_dat_i combinationally. Next state: ACK.
- Zero-lane write (we=1, sel=0): no BRAM write. Next state: ACK.
- Partial write (we=1, sel otherwise): IDLE -> RMW.
  - In RMW, bram_rdata holds the old word.
  - bram_wdata = byte-merge: lane i takes captured wdata if sel[i]=1, else bram_rdata.
  - bram_w_en=1, bram_addr = captured address.
  - Next state: ACK.
- Read (we=0): IDLE -> RD_WAIT.
  - In RD_WAIT, register bram_rdata into wb_dat_o. Next state: ACK.
  - Reads ignore sel and return the full word.
- ACK: wb_ack_o=1 for exactly one cycle. wb_stb_i is ignored in this state. Next state: IDLE.
- Abort: if wb_cyc_i=0 in RD_WAIT or RMW, go to IDLE with no BRAM write and no ack. If wb_cyc_i=0 in ACK, suppress wb_ack_o: wb_ack_o = (state==ACK) & wb_cyc_i.
- No error or retry signalling. The entire address space maps to the BRAM.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE.
  - wb_ack_o=0, wb_dat_o=0, bram_w_en=0, bram_wdata=0.
  - bram_addr follows wb_adr_i.
  - Reset in RMW cancels the pending merge write.
- Request sampled at edge E0 (the state is IDLE in the cycle before E0):
  - Full or zero-lane write: wb_ack_o high in cycle E0→E1. BRAM written at E0.
  - Read: RD_WAIT in E0→E1; wb_ack_o and wb_dat_o valid in E1→E2.
  - Partial write: RMW in E0→E1, BRAM written at E1; wb_ack_o in E1→E2.
- Minimum occupancy per transfer: full write 2 cycles; read and partial write 3 cycles. Back-to-back strobes are accepted at the first IDLE cycle after ACK.
- wb_dat_o holds its last value until the next read completes; it is not cleared after ack.
- At most one BRAM write per transfer; bram_w_en is never high in ACK or RD_WAIT.

## Structure
- Package wb_bram_pkg holds:
  - state_t enum {IDLE, RD_WAIT, RMW, ACK};
  - function byte_merge(old, new, sel), parameterised on DATA_WIDTH;
  - localparam helpers for SEL_WIDTH and OFS_WIDTH.
- No sub-module; the BRAM is instantiated beside this block by the parent, not inside it.

## Test plan
- Full write 0xDEADBEEF, byte address 0x0010, sel=4'hF, then read 0x0010 -> bram_w_en one cycle at word 4; ack 1 cycle after stb; read ack 2 cycles after stb with wb_dat_o=0xDEADBEEF.
- Word holds 0x11223344; write 0xAABBCCDD with sel=4'b0101 -> BRAM written once, on the second cycle, with 0x11BB33DD; ack at cycle 2; readback 0x11BB33DD.
- Write sel=0 to a word holding 0x12345678 -> ack after 1 cycle, no bram_w_en pulse; readback 0x12345678.
- Partial write with wb_cyc_i dropped during RMW -> no bram_w_en, no ack, FSM back in IDLE; word unchanged.
- Assert rst during RD_WAIT -> wb_ack_o, wb_dat_o and bram_w_en go to 0 immediately (asynchronously); FSM in IDLE; the next read completes normally.
- Back-to-back: write word 0x3FFF (byte address 0xFFFC) then read word 0 then read 0x3FFF -> correct data, ack spacing 2/3/3 cycles, no address aliasing at the top of the range.
